// File: rtl/fifo_pkg.sv
// Shared sizing helpers and level-update encoding for the bulk FIFO family.
package fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int fifo_depth(input int bulk_of_data, input int bulk_depth);
    return bulk_of_data * bulk_depth;
  endfunction

  // A margin wider than the FIFO clamps the threshold to zero (flag always set).
  function automatic int almost_full_threshold(input int depth, input int margin);
    return (margin >= depth) ? 0 : depth - margin;
  endfunction

  localparam int DEFAULT_DATA_WIDTH         = 32;
  localparam int DEFAULT_BULK_OF_DATA       = 8;
  localparam int DEFAULT_BULK_DEPTH         = 64;
  localparam int DEFAULT_ALMOST_FULL_MARGIN = 8;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_INC  = 2'd1,
    LVL_DEC  = 2'd2
  } level_op_e;

endpackage

// File: rtl/bulk_fifo_ram.sv
// Simple dual-port storage: synchronous write, registered read that holds when idle.
module bulk_fifo_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 512,
  parameter int AW         = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register carries the reset so rdata is defined as zero after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bulk_sync_fifo.sv
// Single-clock bulk FIFO: pointers, occupancy counter, status flags and sticky errors.
module bulk_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int BULK_OF_DATA       = DEFAULT_BULK_OF_DATA,
  parameter int BULK_DEPTH         = DEFAULT_BULK_DEPTH,
  parameter int ALMOST_FULL_MARGIN = DEFAULT_ALMOST_FULL_MARGIN,
  localparam int DEPTH             = fifo_depth(BULK_OF_DATA, BULK_DEPTH),
  localparam int CW                = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  w_enable,
  output logic                  w_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  r_enable,
  output logic                  r_valid,
  output logic                  r_ready,
  output logic [CW-1:0]         level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  error_full,
  output logic                  error_empty,
  input  logic                  error_clear
);

  localparam int AW = clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_L = CW'(DEPTH);
  localparam logic [CW-1:0] BULK_L  = CW'(BULK_OF_DATA);
  localparam logic [CW-1:0] AF_L    = CW'(almost_full_threshold(DEPTH, ALMOST_FULL_MARGIN));
  localparam logic [AW-1:0] LAST_L  = AW'(DEPTH - 1);

  logic [AW-1:0] w_ptr_reg;
  logic [AW-1:0] r_ptr_reg;
  logic [CW-1:0] level_reg;
  logic          r_valid_reg;
  logic          error_full_reg;
  logic          error_empty_reg;
  logic          wr;
  logic          rd;
  logic          overflow;
  logic          underflow;
  level_op_e     level_op;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_L) ? '0 : p + 1'b1;
  endfunction

  assign empty       = (level_reg == '0);
  assign full        = (level_reg == DEPTH_L);
  assign w_ready     = ~full;
  assign r_ready     = (level_reg >= BULK_L);
  assign almost_full = (level_reg >= AF_L);
  assign level       = level_reg;
  assign r_valid     = r_valid_reg;
  assign error_full  = error_full_reg;
  assign error_empty = error_empty_reg;

  // Flush masks every request and every error event in its cycle.
  assign wr        = w_enable & ~full & ~clr;
  assign rd        = r_enable & ~empty & ~clr;
  assign overflow  = w_enable & full & ~clr;
  assign underflow = r_enable & empty & ~clr;

  always_comb begin
    level_op = LVL_HOLD;
    if (wr && !rd) level_op = LVL_INC;
    else if (rd && !wr) level_op = LVL_DEC;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_reg   <= '0;
      r_ptr_reg   <= '0;
      level_reg   <= '0;
      r_valid_reg <= 1'b0;
    end else if (clr) begin
      w_ptr_reg   <= '0;
      r_ptr_reg   <= '0;
      level_reg   <= '0;
      r_valid_reg <= 1'b0;
    end else begin
      if (wr) w_ptr_reg <= next_ptr(w_ptr_reg);
      if (rd) r_ptr_reg <= next_ptr(r_ptr_reg);
      case (level_op)
        LVL_INC: level_reg <= level_reg + 1'b1;
        LVL_DEC: level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
      r_valid_reg <= rd;
    end
  end

  // A fresh error event outranks a simultaneous error_clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_full_reg  <= 1'b0;
      error_empty_reg <= 1'b0;
    end else begin
      if (overflow) error_full_reg <= 1'b1;
      else if (error_clear) error_full_reg <= 1'b0;
      if (underflow) error_empty_reg <= 1'b1;
      else if (error_clear) error_empty_reg <= 1'b0;
    end
  end

  bulk_fifo_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .AW        (AW)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (wr),
    .waddr(w_ptr_reg),
    .wdata(wdata),
    .re   (rd),
    .raddr(r_ptr_reg),
    .rdata(rdata)
  );

endmodule
